// File: rtl/uart_pkg.sv
// Shared constants and types for the oversampling UART receiver.
// Holds FSM encodings, oversampling geometry and the majority helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int OVS       = 16;
  localparam int SAMPLE_LO = 7;
  localparam int SAMPLE_HI = 9;
  localparam int DATA_BITS = 8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receiver output bundle: data, done/err pulses and busy flag.
// master drives (receiver), slave observes (consumer).
interface uart_rx_ovs_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_done;
  logic                 o_rx_busy;
  logic                 o_frame_err;

  modport master (
    output o_rx_data,
    output o_rx_done,
    output o_rx_busy,
    output o_frame_err
  );

  modport slave (
    input o_rx_data,
    input o_rx_done,
    input o_rx_busy,
    input o_frame_err
  );

endinterface

// File: rtl/uart_rx_ovs_sync_ff.sv
// STAGES-deep single-bit synchronizer, resets to 1 (idle line).
// Ports: clk, reset (async high), d_i async in, q_o synchronized out.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver, 8N1, 2-of-3 majority per bit.
// Ports: clk, reset, baud_tick, i_rx; outputs via rx_if (master).
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          baud_tick,
  input  logic          i_rx,
  uart_rx_ovs_if.master rx_if
);

  logic                 rx_s;
  state_e               state_q;
  logic [3:0]           tick_q;
  logic [3:0]           tick_d;
  logic [2:0]           bit_q;
  logic [1:0]           smp_q;
  logic                 bit_d;
  logic                 armed_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (i_rx),
    .q_o  (rx_s)
  );

  // tick_q holds the index of the last processed tick in the bit;
  // the start-detect tick is index 0, and the 4-bit wrap from 15
  // makes the first tick of the next bit index 0.
  assign tick_d = tick_q + 4'd1;
  assign bit_d  = maj3(smp_q[1], smp_q[0], rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      armed_q <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (baud_tick) begin
        if (state_q != IDLE) begin
          tick_q <= tick_d;
          if (tick_d == 4'(SAMPLE_LO))
            smp_q[1] <= rx_s;
          if (tick_d == 4'(SAMPLE_LO + 1))
            smp_q[0] <= rx_s;
        end
        unique case (state_q)
          IDLE: begin
            if (rx_s) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (tick_d == 4'(SAMPLE_HI) && bit_d) begin
              state_q <= IDLE;
              tick_q  <= '0;
              busy_q  <= 1'b0;
            end else if (tick_d == 4'(OVS - 1)) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (tick_d == 4'(SAMPLE_HI))
              shreg_q <= {bit_d, shreg_q[DATA_BITS-1:1]};
            if (tick_d == 4'(OVS - 1)) begin
              if (bit_q == 3'(DATA_BITS - 1))
                state_q <= STOP;
              else
                bit_q <= bit_q + 3'd1;
            end
          end
          STOP: begin
            // Leave mid-stop so an early next start edge is caught.
            if (tick_d == 4'(SAMPLE_HI)) begin
              state_q <= IDLE;
              tick_q  <= '0;
              busy_q  <= 1'b0;
              if (bit_d) begin
                data_q <= shreg_q;
                done_q <= 1'b1;
              end else begin
                err_q   <= 1'b1;
                armed_q <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_if.o_rx_data   = data_q;
  assign rx_if.o_rx_done   = done_q;
  assign rx_if.o_rx_busy   = busy_q;
  assign rx_if.o_frame_err = err_q;

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of flip-flops in the i_rx input synchronizer (minimum 2).
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 baud_tick  input  1  one-clk-wide pulse at 16x the bit rate (9600 bps x 16).
REQ-005 i_rx  input  1  asynchronous serial line; idles high.
REQ-006 o_rx_data  output  8  last correctly received byte.
REQ-007 o_rx_done  output  1  one-cycle pulse when a valid frame completes.
REQ-008 o_rx_busy  output  1  high while a frame is in progress.
REQ-009 o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-010 Frame format: 1 start (0), 8 data LSB first, 1 stop (1), no parity.
REQ-011 i_rx shall pass through SYNC_STAGES flops; these reset to 1; all logic uses the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP. A 4-bit tick counter and a 3-bit bit counter shall advance only on baud_tick.
REQ-013 IDLE: an armed flag is set by any baud_tick with rx_s=1; on baud_tick with rx_s=0 and armed=1, go to START with tick_cnt=0; o_rx_busy=1 from the next cycle.
REQ-014 Bit decision: sample rx_s at tick_cnt 7, 8 and 9; the 2-of-3 majority is the bit value, decided on the tick_cnt=9 tick.
REQ-015 START: if the majority is 1, this is a false start; go to IDLE, busy=0, no output pulse. Otherwise, at tick_cnt=15, go to DATA with tick_cnt=0 and bit_cnt=0.
REQ-016 DATA: at the decision tick, shift the majority into bit 7 of an 8-bit shift register (shift right). At tick_cnt=15, if bit_cnt=7, go to STOP with tick_cnt=0; else increment bit_cnt.
REQ-017 STOP, stop bit decided at tick_cnt=9 and 1: o_rx_data <= shift register, o_rx_done=1, go to IDLE.
REQ-018 STOP, stop bit decided at tick_cnt=9 and 0: o_frame_err=1, o_rx_data unchanged, armed cleared, go to IDLE.
REQ-019 STOP exits at tick 9, not 15, so a following start edge up to 6 ticks early is still caught.
REQ-020 Outputs are registered; o_rx_done and o_frame_err are high for exactly one clk, in the cycle after the deciding baud_tick.
REQ-021 Latency: with the start-detect tick as T0, the done/err pulse follows tick T0+153 (9x16+9).
REQ-022 No baud_tick: all state and counters hold.
REQ-023 o_rx_busy falls in the same cycle that o_rx_done or o_frame_err rises.
REQ-024 Line stuck low (break) yields exactly one o_frame_err and no restart until rx_s returns high (armed rule).

Reset
REQ-025 Reset state: state=IDLE, counters=0, shift register=0, o_rx_data=8'h00, o_rx_done=0, o_frame_err=0, o_rx_busy=0, synchronizer=1, armed=0.
REQ-026 Reset mid-frame abandons the frame with no pulses; reception resumes from IDLE once rx_s is seen high.

Structure
REQ-027 A shared package uart_pkg shall hold the state encodings (IDLE/START/DATA/STOP), OVS=16, SAMPLE_LO=7, SAMPLE_HI=9, and DATA_BITS=8.
REQ-028 One sub-module, sync_ff (SYNC_STAGES-deep bit synchronizer with reset value 1), is instantiated for i_rx; everything else is flat.

Verification
REQ-029 Send 0x55 at 16 ticks/bit: o_rx_data=0x55, one o_rx_done pulse after tick T0+153, no o_frame_err.
REQ-030 Send 0xA3 then 0x00 back-to-back with the second start bit 4 ticks early: both bytes received in order, two done pulses.
REQ-031 Low glitch of 4 ticks while idle: busy pulses briefly, false start, no done or err, FSM returns to IDLE.
REQ-032 Send 0xFF with stop=0, line held low 40 ticks then high: exactly one o_frame_err, o_rx_data keeps its prior value, no o_rx_done.
REQ-033 Single-tick inversion at tick_cnt=8 of every data bit of 0x96: majority vote gives o_rx_data=0x96.
REQ-034 Reset pulse during data bit 4, then send 0x3C: all outputs at reset values during reset, no pulse for the aborted frame, then 0x3C received correctly.
